// File: rtl/perf_monitor_pkg.sv
// perf_pkg: shared window-FSM states, segment constants and the hex-digit decoder
// for the performance monitor.
package perf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [6:0] BLANK_SEG = 7'h7F;
  localparam logic [6:0] ZERO_SEG  = 7'h40;

  // Active-low segments, bit order g..a
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = BLANK_SEG;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/perf_monitor_hex7seg.sv
// hex7seg: combinational single-digit decoder; the parent registers the result.
module hex7seg
  import perf_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] seg
);

  // Blank overrides the decoded digit
  always_comb begin
    if (blank) begin
      seg = BLANK_SEG;
    end else begin
      seg = hex_to_seg(nib);
    end
  end

endmodule

// File: rtl/perf_monitor.sv
// perf_monitor: PC-windowed cycle and event counters with sticky saturation flags,
// a selectable nibble window on the 7-segment digits and status LEDs.
module perf_monitor
  import perf_pkg::*;
#(
  parameter int                  NUM_CH     = 4,
  parameter int                  CNT_WIDTH  = 32,
  parameter int                  PC_WIDTH   = 15,
  parameter logic [PC_WIDTH-1:0] START_PC   = {PC_WIDTH{1'b0}},
  parameter logic [PC_WIDTH-1:0] FINAL_PC   = PC_WIDTH'(32'd1023),
  parameter int                  NUM_DIGITS = 3
) (
  input  logic                    CLK_50,
  input  logic                    resetN,
  input  logic [PC_WIDTH-1:0]     pc,
  input  logic                    pc_valid,
  input  logic [NUM_CH-1:0]       events,
  input  logic                    clear,
  input  logic [2:0]              sel_ch,
  input  logic [2:0]              sel_nib,
  output logic [7*NUM_DIGITS-1:0] hex,
  output logic [9:0]              led,
  output logic                    finished
);

  localparam int                   NCNT     = NUM_CH + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                          state_r, next_s;
  logic                            count_en_s, start_hit_s, final_hit_s;
  logic [NCNT-1:0]                 hit_en_s, ovf_s;
  logic [NCNT-1:0][CNT_WIDTH-1:0]  cnt_s;
  logic [CNT_WIDTH-1:0]            sel_cnt_s;
  logic [6:0]                      ch_ovf_s;
  logic [9:0]                      led_r;
  logic [7*NUM_DIGITS-1:0]         seg_s, hex_r;

  assign start_hit_s = pc_valid && (pc == START_PC);
  assign final_hit_s = pc_valid && (pc == FINAL_PC);

  // Window FSM next state and count enable; clear overrides any match or event
  always_comb begin
    next_s     = state_r;
    count_en_s = 1'b0;
    if (clear) begin
      next_s     = IDLE;
      count_en_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          count_en_s = start_hit_s;
          if (start_hit_s) begin
            next_s = (START_PC == FINAL_PC) ? DONE : RUN;
          end else begin
            next_s = IDLE;
          end
        end
        RUN: begin
          count_en_s = 1'b1;
          if (final_hit_s) begin
            next_s = DONE;
          end else begin
            next_s = RUN;
          end
        end
        DONE:    next_s = DONE;
        default: next_s = IDLE;
      endcase
    end
  end

  // Window FSM state register
  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Slot 0 is the cycle counter, slot k+1 is event channel k
  assign hit_en_s = {events, 1'b1} & {NCNT{count_en_s}};

  for (genvar i = 0; i < NCNT; i++) begin : g_cnt
    logic [CNT_WIDTH-1:0] cnt_r;
    logic                 ovf_r, at_max_s;

    assign at_max_s = &cnt_r;

    // Saturating counter: an increment at full scale holds and sets the sticky flag
    always_ff @(posedge CLK_50 or negedge resetN) begin
      if (!resetN) begin
        cnt_r <= CNT_ZERO;
        ovf_r <= 1'b0;
      end else if (clear) begin
        cnt_r <= CNT_ZERO;
        ovf_r <= 1'b0;
      end else if (hit_en_s[i]) begin
        cnt_r <= at_max_s ? cnt_r : cnt_r + CNT_ONE;
        ovf_r <= ovf_r | at_max_s;
      end else begin
        cnt_r <= cnt_r;
        ovf_r <= ovf_r;
      end
    end

    assign cnt_s[i] = cnt_r;
    assign ovf_s[i] = ovf_r;
  end

  // Display source: cycle counter unless sel_ch names an existing channel
  always_comb begin
    sel_cnt_s = ((sel_ch == 3'd0) || (int'(sel_ch) > NUM_CH)) ? cnt_s[0] : CNT_ZERO;
    for (int k = 1; k < NCNT; k++) begin
      sel_cnt_s = sel_cnt_s | ((int'(sel_ch) == k) ? cnt_s[k] : CNT_ZERO);
    end
  end

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
    logic [3:0] idx_s, nib_s;
    logic       blank_s;

    assign idx_s   = {1'b0, sel_nib} + 4'(d);
    assign blank_s = (int'(idx_s) >= CNT_WIDTH / 4);
    assign nib_s   = 4'(sel_cnt_s >> {idx_s, 2'b00});

    hex7seg u_hex7seg (
      .nib   (nib_s),
      .blank (blank_s),
      .seg   (seg_s[7*d +: 7])
    );
  end

  for (genvar k = 0; k < 7; k++) begin : g_led
    if (k < NUM_CH) begin : g_ch
      assign ch_ovf_s[k] = ovf_s[k + 1];
    end else begin : g_none
      assign ch_ovf_s[k] = 1'b0;
    end
  end

  // Output registers; status bits follow the state being entered
  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN) begin
      led_r <= 10'd0;
      hex_r <= {NUM_DIGITS{ZERO_SEG}};
    end else begin
      led_r <= {ch_ovf_s, |ovf_s, next_s == DONE, next_s == RUN};
      hex_r <= seg_s;
    end
  end

  assign led      = led_r;
  assign hex      = hex_r;
  assign finished = led_r[1];

endmodule

// File: tb/tb_perf_monitor.sv
// tb_perf_monitor: three differently configured monitors share one stimulus stream;
// a window/counter reference model feeds a scoreboard checked every cycle.
module tb_perf_monitor;

  logic        CLK_50 = 1'b0;
  logic        resetN = 1'b0;
  logic [14:0] pc = 15'd0;
  logic        pc_valid = 1'b0;
  logic [3:0]  events = 4'd0;
  logic        clear = 1'b0;
  logic [2:0]  sel_ch = 3'd0;
  logic [2:0]  sel_nib = 3'd0;
  logic [20:0] hex_o [3];
  logic [9:0]  led_o [3];
  logic        fin_o [3];

  always #10 CLK_50 = ~CLK_50;

  perf_monitor #(.NUM_CH(4), .CNT_WIDTH(32), .PC_WIDTH(15), .START_PC(15'd4),
                 .FINAL_PC(15'd20), .NUM_DIGITS(3)) u_dut0 (
    .CLK_50(CLK_50), .resetN(resetN), .pc(pc), .pc_valid(pc_valid), .events(events),
    .clear(clear), .sel_ch(sel_ch), .sel_nib(sel_nib), .hex(hex_o[0]), .led(led_o[0]),
    .finished(fin_o[0]));

  perf_monitor #(.NUM_CH(4), .CNT_WIDTH(8), .PC_WIDTH(15), .START_PC(15'd4),
                 .FINAL_PC(15'd400), .NUM_DIGITS(3)) u_dut1 (
    .CLK_50(CLK_50), .resetN(resetN), .pc(pc), .pc_valid(pc_valid), .events(events),
    .clear(clear), .sel_ch(sel_ch), .sel_nib(sel_nib), .hex(hex_o[1]), .led(led_o[1]),
    .finished(fin_o[1]));

  perf_monitor #(.NUM_CH(4), .CNT_WIDTH(16), .PC_WIDTH(15), .START_PC(15'd8),
                 .FINAL_PC(15'd8), .NUM_DIGITS(3)) u_dut2 (
    .CLK_50(CLK_50), .resetN(resetN), .pc(pc), .pc_valid(pc_valid), .events(events),
    .clear(clear), .sel_ch(sel_ch), .sel_nib(sel_nib), .hex(hex_o[2]), .led(led_o[2]),
    .finished(fin_o[2]));

  localparam int P_START [3] = '{4, 4, 8};
  localparam int P_FINAL [3] = '{20, 400, 8};
  localparam int P_W     [3] = '{32, 8, 16};
  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02,
    7'h78, 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct packed {
    int              cyc;
    logic [2:0][20:0] hex;
    logic [2:0][9:0]  led;
    logic [2:0]       fin;
  } exp_t;

  exp_t   exp_q [$];
  longint m_cnt [3][5];
  bit     m_ovf [3][5];
  int     m_st  [3];          // 0 idle, 1 measuring, 2 finished
  int     cyc_n   = 0;
  int     n_total = 0;
  int     n_pass  = 0;

  function automatic void model_reset(int i);
    for (int c = 0; c < 5; c++) begin
      m_cnt[i][c] = 0;
      m_ovf[i][c] = 1'b0;
    end
    m_st[i] = 0;
  endfunction

  function automatic void model_step(int i, int p, bit pv, logic [3:0] ev, bit clr);
    bit       opens, counted;
    logic [4:0] hits;
    longint   maxv;
    maxv = (longint'(1) << P_W[i]) - 1;
    if (clr) begin
      model_reset(i);
      return;
    end
    opens   = (m_st[i] == 0) && pv && (p == P_START[i]);
    counted = (m_st[i] == 1) || opens;
    hits    = {ev, 1'b1};
    if (counted) begin
      for (int c = 0; c < 5; c++) begin
        if (hits[c]) begin
          if (m_cnt[i][c] == maxv) m_ovf[i][c] = 1'b1;
          else m_cnt[i][c] = m_cnt[i][c] + 1;
        end
      end
    end
    if (opens) m_st[i] = (P_START[i] == P_FINAL[i]) ? 2 : 1;
    else if ((m_st[i] == 1) && pv && (p == P_FINAL[i])) m_st[i] = 2;
  endfunction

  function automatic logic [20:0] exp_hex(int i, logic [2:0] sc, logic [2:0] sn);
    int          src, nib;
    longint      v;
    logic [20:0] r;
    src = ((sc == 3'd0) || (int'(sc) > 4)) ? 0 : int'(sc);
    v   = m_cnt[i][src];
    for (int d = 0; d < 3; d++) begin
      nib = int'(sn) + d;
      if (nib >= P_W[i] / 4) r[7*d +: 7] = 7'h7F;
      else r[7*d +: 7] = SEG[int'((v >> (4 * nib)) & 15)];
    end
    return r;
  endfunction

  // rmode: 0 = reset released, 1 = reset held low, 2 = reset dropped just after the edge
  task automatic step(input int p, input logic pv, input logic [3:0] ev, input logic clr,
                      input logic [2:0] sc, input logic [2:0] sn, input int rmode);
    exp_t       e;
    logic [9:0] l;
    bit         any_ovf;
    pc = 15'(p); pc_valid = pv; events = ev; clear = clr; sel_ch = sc; sel_nib = sn;
    if (rmode == 0) resetN = 1'b1;
    else if (rmode == 1) resetN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (rmode != 0) begin
        e.hex[i] = {3{7'h40}};
        e.led[i] = 10'd0;
        e.fin[i] = 1'b0;
        model_reset(i);
      end else begin
        e.hex[i] = exp_hex(i, sc, sn);
        l = 10'd0;
        any_ovf = 1'b0;
        for (int c = 0; c < 5; c++) any_ovf = any_ovf | m_ovf[i][c];
        for (int k = 0; k < 4; k++) l[3 + k] = m_ovf[i][k + 1];
        l[2] = any_ovf;
        model_step(i, p, pv, ev, clr);
        l[1] = (m_st[i] == 2);
        l[0] = (m_st[i] == 1);
        e.led[i] = l;
        e.fin[i] = (m_st[i] == 2);
      end
    end
    @(posedge CLK_50);
    #2;
    if (rmode == 2) resetN = 1'b0;
    #1;
    e.cyc = cyc_n;
    exp_q.push_back(e);
    cyc_n++;
    @(negedge CLK_50);
  endtask

  task automatic chk(input string nm, input int d, input int cyc, input logic [31:0] act,
                     input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s dut%0d cycle %0d: got %h expected %h", nm, d, cyc, act, want);
  endtask

  // Scoreboard monitor: one expectation per clock, compared mid-cycle
  always @(negedge CLK_50) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int i = 0; i < 3; i++) begin
        chk("hex", i, e.cyc, {11'd0, hex_o[i]}, {11'd0, e.hex[i]});
        chk("led", i, e.cyc, {22'd0, led_o[i]}, {22'd0, e.led[i]});
        chk("finished", i, e.cyc, {31'd0, fin_o[i]}, {31'd0, e.fin[i]});
      end
    end
  end

  task automatic sweep_display();
    for (int sc = 0; sc < 6; sc++)
      for (int sn = 0; sn < 8; sn++)
        step(0, 1'b0, 4'd0, 1'b0, 3'(sc), 3'(sn), 0);
  endtask

  initial begin
    int p;
    repeat (3) step(0, 1'b0, 4'd0, 1'b0, 3'd0, 3'd0, 1);
    // Window pass: events[0] tied high
    for (int k = 0; k <= 25; k++) step(k, 1'b1, 4'b0001, 1'b0, 3'd0, 3'd0, 0);
    sweep_display();
    // Second pass: closed windows must ignore further matches
    for (int k = 0; k <= 25; k++) step(k, 1'b1, 4'b0101, 1'b0, 3'd1, 3'd0, 0);
    // clear in DONE on a START match, then restart on the next match
    step(4, 1'b1, 4'b1111, 1'b1, 3'd0, 3'd0, 0);
    step(4, 1'b1, 4'b0001, 1'b0, 3'd0, 3'd0, 0);
    step(0, 1'b0, 4'd0, 1'b0, 3'd0, 3'd0, 0);
    // Saturation of channel 1 in the 8-bit monitor
    repeat (300) step(0, 1'b0, 4'b0010, 1'b0, 3'd2, 3'd0, 0);
    step(20, 1'b1, 4'd0, 1'b0, 3'd2, 3'd0, 0);
    sweep_display();
    // Random traffic
    repeat (600) begin
      case ($urandom_range(0, 4))
        0: p = 400;
        1: p = 8;
        2: p = 4;
        3: p = 20;
        default: p = int'($urandom_range(0, 25));
      endcase
      step(p, 1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom_range(0, 49) == 0),
           3'($urandom), 3'($urandom), 0);
    end
    // Reset in the tenth cycle of a window, then idle until START
    step(0, 1'b0, 4'd0, 1'b1, 3'd0, 3'd0, 0);
    for (int k = 4; k <= 12; k++) step(k, 1'b1, 4'b0011, 1'b0, 3'd0, 3'd0, 0);
    step(13, 1'b1, 4'b0011, 1'b0, 3'd0, 3'd0, 2);
    step(14, 1'b1, 4'b0011, 1'b0, 3'd0, 3'd0, 1);
    repeat (4) step(5, 1'b1, 4'b1111, 1'b0, 3'd0, 3'd0, 0);
    for (int k = 4; k <= 7; k++) step(k, 1'b1, 4'b1001, 1'b0, 3'd4, 3'd0, 0);
    repeat (2) step(0, 1'b0, 4'd0, 1'b0, 3'd0, 3'd0, 0);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
